// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the fetch, decode and hazard units.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: byte address out, instruction word back in the same cycle.
interface instr_fetch_unit_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_instr;

   modport master (output imem_addr, input imem_instr);
   modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux (jump > branch > sequential) and the bad-PC detector.
module fetch_next_pc
   import mips_pkg::*;
#(
   parameter int IMEM_DEPTH = 100
) (
   input  logic [31:0] pc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        pc_bad
);

   localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

   assign pc_plus4 = pc + 32'd4;

   // Word index compared against depth, so a misaligned or out-of-range pc both count as bad.
   assign pc_bad = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= DEPTH_WORDS);

   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = jump_target;
      else if (branch_taken)
         next_pc = branch_target;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, the IF/ID latch and the RUN/HALT fault FSM.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IMEM_DEPTH = 100
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      branch_taken,
   input  logic [31:0]               branch_target,
   input  logic                      jump,
   input  logic [31:0]               jump_target,
   instr_fetch_unit_if.master        imem,
   output logic [31:0]               if_id_instr,
   output logic [31:0]               if_id_pc_plus4,
   output logic                      if_id_valid,
   output logic                      fetch_fault,
   output logic [31:0]               fault_pc,
   output logic [31:0]               fetch_count
);

   fetch_state_t state, next_state;

   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        pc_bad;

   logic        pc_load;
   logic        ifid_load;
   logic        ifid_kill;
   logic        fault_set;

   assign imem.imem_addr = pc;

   fetch_next_pc #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_next_pc (
      .pc            (pc),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .pc_plus4      (pc_plus4),
      .pc_bad        (pc_bad)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= RUN;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (state == RUN && pc_bad)
         next_state = HALT;
   end

   // A bad pc wins over every control input so its instruction never reaches IF/ID.
   always_comb begin
      pc_load   = 1'b0;
      ifid_load = 1'b0;
      ifid_kill = 1'b0;
      fault_set = 1'b0;
      if (state == RUN) begin
         if (pc_bad) begin
            fault_set = 1'b1;
            ifid_kill = 1'b1;
         end else if (jump || branch_taken) begin
            pc_load   = 1'b1;
            ifid_kill = 1'b1;
         end else if (stall) begin
            ifid_kill = flush;
         end else if (flush) begin
            pc_load   = 1'b1;
            ifid_kill = 1'b1;
         end else begin
            pc_load   = 1'b1;
            ifid_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc             <= RESET_PC;
         if_id_instr    <= NOP_INSTR;
         if_id_pc_plus4 <= 32'h0;
         if_id_valid    <= 1'b0;
         fetch_fault    <= 1'b0;
         fault_pc       <= 32'h0;
         fetch_count    <= 32'h0;
      end else begin
         if (pc_load)
            pc <= next_pc;
         if (ifid_kill) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (ifid_load) begin
            if_id_instr    <= imem.imem_instr;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
         end
         if (fault_set) begin
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit with a 100-word combinational instruction memory.
module tb_instr_fetch_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] if_id_instr, if_id_pc_plus4, fault_pc, fetch_count;
   logic        if_id_valid, fetch_fault;

   logic [31:0] mem [0:99];
   int          vectors = 0;
   int          miscompares = 0;

   instr_fetch_unit_if imem_bus ();

   instr_fetch_unit #(
      .RESET_PC   (32'h0),
      .IMEM_DEPTH (100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .imem           (imem_bus.master),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_fault    (fetch_fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   // Out-of-range reads return a marker that must never appear in IF/ID.
   always_comb begin
      if (imem_bus.imem_addr[31:2] < 30'd100)
         imem_bus.imem_instr = mem[imem_bus.imem_addr[8:2]];
      else
         imem_bus.imem_instr = 32'hDEAD_BEEF;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic j, input logic [31:0] jt, input logic b,
                                input logic [31:0] bt, input logic s, input logic f);
      jump          = j;
      jump_target   = jt;
      branch_taken  = b;
      branch_target = bt;
      stall         = s;
      flush         = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 100; i++)
         mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      mem[2] = 32'h0109_5020;

      rst = 1'b1;
      idle();
      idle();
      checkOutput("rst_pc",    imem_bus.imem_addr, 32'h0);
      checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("rst_instr", if_id_instr, 32'h0);
      checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
      checkOutput("rst_count", fetch_count, 32'h0);
      rst = 1'b0;

      idle();
      checkOutput("run1_instr", if_id_instr, 32'h2008_0005);
      checkOutput("run1_pc4",   if_id_pc_plus4, 32'h4);
      checkOutput("run1_valid", {31'b0, if_id_valid}, 32'h1);
      idle();
      checkOutput("run2_instr", if_id_instr, 32'h2009_0003);
      checkOutput("run2_pc4",   if_id_pc_plus4, 32'h8);

      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("stall_pc",    imem_bus.imem_addr, 32'h8);
      checkOutput("stall_instr", if_id_instr, 32'h2009_0003);
      checkOutput("stall_count", fetch_count, 32'h2);

      idle();
      checkOutput("run3_instr", if_id_instr, 32'h0109_5020);
      checkOutput("run3_pc4",   if_id_pc_plus4, 32'hC);
      checkOutput("run3_pc",    imem_bus.imem_addr, 32'hC);
      checkOutput("run3_count", fetch_count, 32'h3);

      idle();
      checkOutput("pre_br_pc", imem_bus.imem_addr, 32'h10);

      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
      checkOutput("br_pc",    imem_bus.imem_addr, 32'h40);
      checkOutput("br_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("br_instr", if_id_instr, 32'h0);
      idle();
      checkOutput("br_tgt_instr", if_id_instr, 32'h1000_0010);
      checkOutput("br_tgt_pc4",   if_id_pc_plus4, 32'h44);
      checkOutput("br_tgt_count", fetch_count, 32'h5);

      applyStimulus(1'b1, 32'h20, 1'b1, 32'h30, 1'b0, 1'b0);
      checkOutput("jb_pc",    imem_bus.imem_addr, 32'h20);
      checkOutput("jb_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("jb_count", fetch_count, 32'h5);
      idle();
      checkOutput("jb_tgt_instr", if_id_instr, 32'h1000_0008);
      checkOutput("jb_tgt_pc4",   if_id_pc_plus4, 32'h24);
      checkOutput("jb_tgt_count", fetch_count, 32'h6);

      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("flush_pc",    imem_bus.imem_addr, 32'h28);
      checkOutput("flush_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("flush_count", fetch_count, 32'h6);

      applyStimulus(1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("badj_pc",    imem_bus.imem_addr, 32'h22);
      checkOutput("badj_fault", {31'b0, fetch_fault}, 32'h0);
      idle();
      checkOutput("badj_fault1", {31'b0, fetch_fault}, 32'h1);
      checkOutput("badj_fpc",    fault_pc, 32'h22);
      checkOutput("badj_valid",  {31'b0, if_id_valid}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i[0], 32'h0, 1'b1, 32'h4, i[1], ~i[0]);
         checkOutput("halt_pc",    imem_bus.imem_addr, 32'h22);
         checkOutput("halt_count", fetch_count, 32'h6);
         checkOutput("halt_fault", {31'b0, fetch_fault}, 32'h1);
         checkOutput("halt_fpc",   fault_pc, 32'h22);
      end

      rst = 1'b1;
      idle();
      rst = 1'b0;
      checkOutput("rst2_pc",    imem_bus.imem_addr, 32'h0);
      checkOutput("rst2_fault", {31'b0, fetch_fault}, 32'h0);
      checkOutput("rst2_count", fetch_count, 32'h0);

      applyStimulus(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int w = 96; w < 100; w++) begin
         idle();
         checkOutput("tail_instr", if_id_instr, 32'h1000_0000 + w);
         checkOutput("tail_pc4",   if_id_pc_plus4, 32'(4 * (w + 1)));
      end
      checkOutput("tail_pc", imem_bus.imem_addr, 32'h190);
      idle();
      checkOutput("oor_fault", {31'b0, fetch_fault}, 32'h1);
      checkOutput("oor_fpc",   fault_pc, 32'h190);
      checkOutput("oor_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("oor_instr", if_id_instr, 32'h0);
      checkOutput("oor_pc4",   if_id_pc_plus4, 32'h190);
      checkOutput("oor_count", fetch_count, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
